// File: rtl/ofdm_equalizer_n.sv
// ofdm_equalizer_n: per-subcarrier complex equalizer between FFT and demapper.
// A training symbol stores C_k = conj(H_k) for every bin k; each later data
// sample Y_k leaves as round(Y_k * C_k >> SHIFT), saturated to DW bits per rail.
// Ports:
//   axis_aclk, axis_areset         clock, async active-high reset
//   s00_axis_*                     input stream, tdata = {Q, I}
//   m00_axis_*                     equalized output stream, same packing
//   train_req                      pulse: next symbol boundary starts a training symbol
//   trained                        a coefficient set is loaded
//   symbol_err                     one-cycle pulse on a tlast framing error
module ofdm_equalizer_n #(
    parameter int unsigned DW    = 16,
    parameter int unsigned NFFT  = 64,
    parameter int unsigned SHIFT = 15
) (
    input  logic              axis_aclk,
    input  logic              axis_areset,
    input  logic [2*DW-1:0]   s00_axis_tdata,
    input  logic              s00_axis_tvalid,
    output logic              s00_axis_tready,
    input  logic              s00_axis_tlast,
    output logic [2*DW-1:0]   m00_axis_tdata,
    output logic              m00_axis_tvalid,
    input  logic              m00_axis_tready,
    output logic [2*DW/8-1:0] m00_axis_tstrb,
    output logic              m00_axis_tlast,
    input  logic              train_req,
    output logic              trained,
    output logic              symbol_err
);

    localparam int unsigned AW = $clog2(NFFT);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = 2 * DW + 2;

    localparam logic [DW-1:0] SMAX     = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN     = {1'b1, {(DW-1){1'b0}}};
    localparam logic [SW-1:0] RND      = SW'(1) << (SHIFT - 1);
    localparam logic [AW-1:0] LAST_BIN = AW'(NFFT - 1);

    typedef enum logic {
        MODE_DATA  = 1'b0,
        MODE_TRAIN = 1'b1
    } mode_e;

    // Control state
    logic [AW-1:0] bin_q, bin_d;
    mode_e         mode_q, mode_d;
    logic          pend_q, pend_d;
    logic          trained_q, trained_d;
    logic          err_q, err_d;

    // Pipeline state
    logic                 v1_q, v1_d, l1_q, l1_d;
    logic [PW-1:0]        y1_q, y1_d;
    logic                 v2_q, v2_d, l2_q, l2_d;
    logic signed [PW-1:0] p_ac_q, p_ac_d, p_bd_q, p_bd_d;
    logic signed [PW-1:0] p_ad_q, p_ad_d, p_bc_q, p_bc_d;
    logic                 mv_q, mv_d, ml_q, ml_d;
    logic [PW-1:0]        md_q, md_d;

    logic          en, hs, last_bin, train_now, ram_we;
    logic [DW-1:0] in_i, in_q, neg_q;
    logic [PW-1:0] coef_ram [NFFT];
    logic [PW-1:0] coef_rd_q;

    // Mode of the current sample: decided at bin 0, latched for the rest of the symbol
    assign train_now = (bin_q == '0) ? (pend_q | ~trained_q) : (mode_q == MODE_TRAIN);
    assign en        = ~mv_q | m00_axis_tready;
    // Training never needs the output path, so it is accepted even under backpressure
    assign s00_axis_tready = ~axis_areset & (train_now | en);
    assign hs        = s00_axis_tvalid & s00_axis_tready;
    assign last_bin  = (bin_q == LAST_BIN);
    assign ram_we    = hs & train_now;

    assign in_i  = s00_axis_tdata[DW-1:0];
    assign in_q  = s00_axis_tdata[2*DW-1:DW];
    // Conjugate of Q; the most negative value has no positive twin and saturates
    assign neg_q = (in_q == SMIN) ? SMAX : (~in_q + DW'(1));

    // Saturate a wide signed value to DW bits
    function automatic logic [DW-1:0] sat(input logic [SW-1:0] x);
        logic [SW-DW:0] top;
        top = x[SW-1:DW-1];
        if ((&top) || !(|top)) begin
            sat = x[DW-1:0];
        end else if (x[SW-1]) begin
            sat = SMIN;
        end else begin
            sat = SMAX;
        end
    endfunction

    // Coefficient RAM: written during training, read in stage 1 alongside the sample
    always_ff @(posedge axis_aclk) begin
        if (ram_we) begin
            coef_ram[bin_q] <= {neg_q, in_i};
        end
        if (en) begin
            coef_rd_q <= coef_ram[bin_q];
        end
    end

    // Bin counter, mode latch, training status and framing check
    always_comb begin
        bin_d     = bin_q;
        mode_d    = mode_q;
        pend_d    = pend_q | train_req;
        trained_d = trained_q;
        err_d     = 1'b0;
        if (hs) begin
            if (bin_q == '0) begin
                mode_d = train_now ? MODE_TRAIN : MODE_DATA;
            end
            err_d = (s00_axis_tlast != last_bin);
            bin_d = (last_bin || s00_axis_tlast) ? '0 : bin_q + AW'(1);
            // Only a complete training symbol validates the coefficient set
            if (last_bin && train_now) begin
                trained_d = 1'b1;
                pend_d    = train_req;
            end
        end
    end

    // Datapath: stage 1 capture, stage 2 partial products, stage 3 combine/round/saturate
    always_comb begin
        logic signed [DW-1:0] a_s, b_s, c_s, d_s;
        logic signed [SW-1:0] re_sum, im_sum, re_sh, im_sh;

        v1_d = hs & ~train_now;
        l1_d = last_bin | s00_axis_tlast;
        y1_d = s00_axis_tdata;

        a_s    = $signed(y1_q[DW-1:0]);
        b_s    = $signed(y1_q[2*DW-1:DW]);
        c_s    = $signed(coef_rd_q[DW-1:0]);
        d_s    = $signed(coef_rd_q[2*DW-1:DW]);
        v2_d   = v1_q;
        l2_d   = l1_q;
        p_ac_d = PW'(a_s) * PW'(c_s);
        p_bd_d = PW'(b_s) * PW'(d_s);
        p_ad_d = PW'(a_s) * PW'(d_s);
        p_bc_d = PW'(b_s) * PW'(c_s);

        re_sum = SW'(p_ac_q) - SW'(p_bd_q) + $signed(RND);
        im_sum = SW'(p_ad_q) + SW'(p_bc_q) + $signed(RND);
        re_sh  = re_sum >>> SHIFT;
        im_sh  = im_sum >>> SHIFT;
        mv_d   = v2_q;
        ml_d   = l2_q;
        md_d   = {sat(im_sh), sat(re_sh)};
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            bin_q     <= '0;
            mode_q    <= MODE_TRAIN;
            pend_q    <= 1'b1;
            trained_q <= 1'b0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            y1_q      <= '0;
            v2_q      <= 1'b0;
            l2_q      <= 1'b0;
            p_ac_q    <= '0;
            p_bd_q    <= '0;
            p_ad_q    <= '0;
            p_bc_q    <= '0;
            mv_q      <= 1'b0;
            ml_q      <= 1'b0;
            md_q      <= '0;
        end else begin
            bin_q     <= bin_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            trained_q <= trained_d;
            err_q     <= err_d;
            // Whole pipeline advances together, so nothing is lost or reordered on stall
            if (en) begin
                v1_q   <= v1_d;
                l1_q   <= l1_d;
                y1_q   <= y1_d;
                v2_q   <= v2_d;
                l2_q   <= l2_d;
                p_ac_q <= p_ac_d;
                p_bd_q <= p_bd_d;
                p_ad_q <= p_ad_d;
                p_bc_q <= p_bc_d;
                mv_q   <= mv_d;
                ml_q   <= ml_d;
                md_q   <= md_d;
            end
        end
    end

    assign m00_axis_tdata  = md_q;
    assign m00_axis_tvalid = mv_q;
    assign m00_axis_tlast  = ml_q;
    assign m00_axis_tstrb  = '1;
    assign trained         = trained_q;
    assign symbol_err      = err_q;

endmodule

// File: tb/tb_ofdm_equalizer_n.sv
// tb_ofdm_equalizer_n: directed bench for ofdm_equalizer_n (DW=16, NFFT=8, SHIFT=15)
// with a behavioural reference model and a per-cycle compare process.
module tb_ofdm_equalizer_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [3:0]  m_tstrb;
    logic        train_req, trained, symbol_err;

    ofdm_equalizer_n #(.DW(16), .NFFT(8), .SHIFT(15)) dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .train_req       (train_req),
        .trained         (trained),
        .symbol_err      (symbol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        l;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          c_re[8];
    int          c_im[8];
    bit          m_trained, m_pend, m_train, exp_err, stall_prev, bp_seen;
    int          m_bin;
    logic [31:0] held_d, last_out;
    int          n_out, n_last, n_err;

    function automatic int rnd_sat(input longint x);
        longint y;
        y = (x + 64'sd16384) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    // Y * C computed as plain complex arithmetic, then rounded and saturated
    function automatic logic [31:0] model_eq(input logic [31:0] y, input int cr, input int ci);
        longint a, b;
        int re, im;
        logic [15:0] re16, im16;
        a  = longint'($signed(y[15:0]));
        b  = longint'($signed(y[31:16]));
        re = rnd_sat(a * cr - b * ci);
        im = rnd_sat(a * ci + b * cr);
        re16 = 16'(re);
        im16 = 16'(im);
        return {im16, re16};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_trained  = 1'b0;
            m_pend     = 1'b1;
            m_bin      = 0;
            exp_err    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            exp_t e;
            bit   done;
            int   iq, ii;
            chk("symbol_err", 32'(symbol_err), 32'(exp_err));
            chk("trained", 32'(trained), 32'(m_trained));
            if (stall_prev) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", m_tdata, held_d);
            end
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no output", m_tdata);
                end else begin
                    e = q.pop_front();
                    chk("out_data", m_tdata, e.d);
                    chk("out_last", 32'(m_tlast), 32'(e.l));
                    if (!bp_seen) chk("latency", 32'(cyc - e.cyc), 32'd3);
                    last_out = m_tdata;
                    n_out++;
                    if (m_tlast) n_last++;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held_d     = m_tdata;
            if (symbol_err) n_err++;

            exp_err = 1'b0;
            done    = 1'b0;
            if (s_tvalid && s_tready) begin
                if (m_bin == 0) m_train = m_pend || !m_trained;
                if (m_train) begin
                    iq = int'($signed(s_tdata[31:16]));
                    ii = int'($signed(s_tdata[15:0]));
                    c_re[m_bin] = ii;
                    c_im[m_bin] = (iq == -32768) ? 32767 : -iq;
                end else begin
                    e.d   = model_eq(s_tdata, c_re[m_bin], c_im[m_bin]);
                    e.l   = s_tlast || (m_bin == 7);
                    e.cyc = cyc;
                    q.push_back(e);
                end
                exp_err = s_tlast != (m_bin == 7);
                if (s_tlast || m_bin == 7) begin
                    done  = m_train && (m_bin == 7);
                    m_bin = 0;
                end else begin
                    m_bin++;
                end
            end
            if (done) begin
                m_trained = 1'b1;
                m_pend    = train_req;
            end else begin
                m_pend = m_pend || train_req;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_sym(input logic [31:0] d);
        for (int k = 0; k < 8; k++) send(d, k == 7);
    endtask

    task automatic pulse_req();
        train_req = 1'b1;
        idle(1);
        train_req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        idle(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n0, e0;
        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1; train_req = 1'b0;
        bp_seen = 1'b0; n_out = 0; n_last = 0; n_err = 0; last_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_trained", 32'(trained), 32'd0);
        chk("rst_symbol_err", 32'(symbol_err), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("tstrb", 32'(m_tstrb), 32'hF);
        chk("model_pin_j", model_eq(32'h00004000, 0, -32767), 32'hC0010000);
        chk("model_pin_sat", model_eq(32'h00008000, -32768, 0), 32'h00007FFF);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // 1: unity-ish channel
        send_sym(32'h00007FFF);
        idle(2);
        chk("t1_trained", 32'(trained), 32'd1);
        n0 = n_out; e0 = n_last;
        send_sym(32'h00003000);
        drain();
        chk("t1_count", 32'(n_out - n0), 32'd8);
        chk("t1_lasts", 32'(n_last - e0), 32'd1);
        chk("t1_value", last_out, 32'h00003000);

        // 2: H = j
        pulse_req();
        send_sym(32'h7FFF0000);
        idle(2);
        send_sym(32'h00004000);
        drain();
        chk("t2_value", last_out, 32'hC0010000);

        // 3: saturation of output and of stored conjugate
        pulse_req();
        send_sym(32'h00008000);
        send_sym(32'h00008000);
        drain();
        chk("t3_out_sat", last_out, 32'h00007FFF);
        pulse_req();
        send_sym(32'h80000000);
        send_sym(32'h00004000);
        drain();
        chk("t3_conj_sat", last_out, 32'h40000000);

        // 4: framing errors with per-bin distinct coefficients
        pulse_req();
        for (int k = 0; k < 8; k++) send({16'h0000, 16'(32'h0800 * (k + 1))}, k == 7);
        e0 = n_err;
        for (int k = 0; k < 6; k++) send(32'h00004000, k == 5);
        send(32'h00004000, 1'b0);
        drain();
        chk("t4_restart_bin0", last_out, 32'h00000400);
        chk("t4_err_pulses", 32'(n_err - e0), 32'd1);
        for (int k = 1; k < 8; k++) send(32'h00004000, k == 7);
        drain();
        chk("t4_trained", 32'(trained), 32'd1);
        chk("t4_bin7", last_out, 32'h00002000);
        e0 = n_err;
        for (int k = 0; k < 8; k++) send(32'h00004000, 1'b0);
        drain();
        chk("t4_missing_last", 32'(n_err - e0), 32'd1);

        // 5: output backpressure mid-symbol
        bp_seen = 1'b1;
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++) send(32'h00004000, k == 7);
            end
            begin
                idle(4);
                m_tready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (i >= 1) chk("t5_s_tready_stall", 32'(s_tready), 32'd0);
                end
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        drain();
        chk("t5_count", 32'(n_out - n0), 32'd8);
        chk("t5_value", last_out, 32'h00002000);

        // 6: train_req mid data symbol
        n0 = n_out;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) train_req = 1'b1;
            send(32'h00004000, k == 7);
            train_req = 1'b0;
        end
        drain();
        chk("t6_old_count", 32'(n_out - n0), 32'd8);
        chk("t6_old_coef", last_out, 32'h00002000);
        n0 = n_out;
        send_sym(32'h00007FFF);
        idle(2);
        chk("t6_train_silent", 32'(n_out - n0), 32'd0);
        send_sym(32'h00004000);
        drain();
        chk("t6_new_coef", last_out, 32'h00004000);

        // 7: reset mid-symbol discards in-flight data and forces training
        for (int k = 0; k < 4; k++) send(32'h00003000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_tvalid", 32'(m_tvalid), 32'd0);
        chk("t7_trained", 32'(trained), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        send_sym(32'h00004000);
        send_sym(32'h00003000);
        drain();
        chk("t7_value", last_out, 32'h00001800);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
